// File: rtl/light_sequencer.sv
// light_sequencer: push-button driven LED colour sequencer.
// A raw button is synchronised and debounced. In MANUAL mode each debounced
// press advances the colour once. In AUTO mode the colour advances every
// dwell+1 cycles while the button is held, and pauses while it is released.
// Colour runs 1..6 and wraps; any illegal code (0 or 7) is forced back to 1.
//
// Handshake note: this block has no valid/ready interfaces. The only
// "transaction" is the step output, a registered one-cycle pulse that is
// high exactly in the cycle a new colour value first appears on colour.
module light_sequencer #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [1:0] mode,
    input  logic [7:0] dwell,
    output logic [2:0] colour,
    output logic       step,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        AUTO   = 2'b10
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

    state_t     cur_state;
    state_t     nxt_state;

    logic       sync1;
    logic       btn_s;
    logic       btn_db;
    logic       btn_db_q;
    logic [7:0] db_cnt;
    logic       press;

    logic [7:0] dwell_cnt;
    logic [7:0] dwell_cnt_nxt;
    logic [2:0] colour_nxt;
    logic       step_nxt;

    // Next colour in the 1..6 ring.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == 3'd6) ? 3'd1 : c + 3'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= button;
            btn_s <= sync1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= 8'd0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= 8'd0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= 8'd0;
        end else begin
            db_cnt <= db_cnt + 8'd1;
        end
    end

    // Previous debounced level, used for rising-edge press detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_db_q <= 1'b0;
        else     btn_db_q <= btn_db;
    end

    assign press = btn_db & ~btn_db_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= IDLE;
        else     cur_state <= nxt_state;
    end

    // Next state from mode, plus colour/step/dwell-counter decisions made
    // from the current state (so a press in the cycle mode leaves MANUAL
    // still steps). The dwell counter is held at zero outside AUTO, which
    // gives the clear-on-entry behaviour without a separate entry term.
    always_comb begin
        nxt_state     = cur_state;
        colour_nxt    = colour;
        step_nxt      = 1'b0;
        dwell_cnt_nxt = dwell_cnt;

        case (mode)
            2'b01:   nxt_state = MANUAL;
            2'b10:   nxt_state = AUTO;
            default: nxt_state = IDLE;
        endcase

        case (cur_state)
            MANUAL: begin
                dwell_cnt_nxt = 8'd0;
                if (press) begin
                    colour_nxt = next_colour(colour);
                    step_nxt   = 1'b1;
                end
            end
            AUTO: begin
                if (btn_db) begin
                    if (dwell_cnt >= dwell) begin
                        colour_nxt    = next_colour(colour);
                        step_nxt      = 1'b1;
                        dwell_cnt_nxt = 8'd0;
                    end else begin
                        dwell_cnt_nxt = dwell_cnt + 8'd1;
                    end
                end
            end
            default: begin
                dwell_cnt_nxt = 8'd0;
            end
        endcase

        // Illegal colour codes are repaired silently, in any state.
        if (colour == 3'd0 || colour == 3'd7) begin
            colour_nxt = 3'd1;
            step_nxt   = 1'b0;
        end
    end

    // Registered colour, step pulse and dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour    <= 3'd1;
            step      <= 1'b0;
            dwell_cnt <= 8'd0;
        end else begin
            colour    <= colour_nxt;
            step      <= step_nxt;
            dwell_cnt <= dwell_cnt_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed testbench for light_sequencer. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the DUT
// updates on the rising edge.
module tb_light_sequencer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [2:0] colour;
    logic       step;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int step_cnt = 0;

    logic [2:0] auto_seq [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

    light_sequencer #(.DEBOUNCE(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .mode   (mode),
        .dwell  (dwell),
        .colour (colour),
        .step   (step),
        .state  (state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance n falling edges, counting step pulses seen on the way.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (step === 1'b1) step_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; button = 1'b0; mode = 2'b00; dwell = 8'd0;
        #2 rst = 1'b1;
        #1;
        total++; if (colour !== 3'd1) begin bad++; $display("FAIL reset_colour: got %0d expected 1", colour); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step: got %0b expected 0", step); end
        total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick(2);
        total++; if (colour !== 3'd1 || state !== 2'b00) begin bad++; $display("FAIL reset_release: got colour=%0d state=%0d expected 1/0", colour, state); end
    endtask

    task automatic test_manual;
        int lat;
        logic [2:0] start;
        mode = 2'b01;
        tick(2);
        total++; if (state !== 2'b01) begin bad++; $display("FAIL manual_state: got %0d expected 1", state); end
        step_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            button = 1'b1;
            lat = 0;
            start = colour;
            for (int k = 1; k <= 20; k++) begin
                tick(1);
                if (lat == 0 && colour !== start) lat = k;
            end
            total++; if (colour !== 3'(p + 2)) begin bad++; $display("FAIL manual_colour%0d: got %0d expected %0d", p, colour, p + 2); end
            total++; if (lat < DB + 2 || lat > DB + 4) begin bad++; $display("FAIL manual_latency%0d: got %0d expected %0d..%0d", p, lat, DB + 2, DB + 4); end
            total++; if (step_cnt != p + 1) begin bad++; $display("FAIL manual_steps%0d: got %0d expected %0d", p, step_cnt, p + 1); end
            button = 1'b0;
            tick(20);
        end
        total++; if (step_cnt != 3) begin bad++; $display("FAIL manual_total_steps: got %0d expected 3", step_cnt); end
    endtask

    task automatic test_bounce;
        step_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(2);
        end
        total++; if (step_cnt != 0) begin bad++; $display("FAIL bounce_steps_toggling: got %0d expected 0", step_cnt); end
        total++; if (colour !== 3'd4) begin bad++; $display("FAIL bounce_colour_toggling: got %0d expected 4", colour); end
        button = 1'b1;
        tick(20);
        total++; if (step_cnt != 1) begin bad++; $display("FAIL bounce_steps_held: got %0d expected 1", step_cnt); end
        total++; if (colour !== 3'd5) begin bad++; $display("FAIL bounce_colour_held: got %0d expected 5", colour); end
    endtask

    task automatic test_auto;
        int k;
        int zero;
        // Start from a known colour of 1.
        #2 rst = 1'b1;
        mode = 2'b10; dwell = 8'd3; button = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (k < 40 && step !== 1'b1) begin tick(1); k++; end
        total++; if (step !== 1'b1 || colour !== auto_seq[0]) begin bad++; $display("FAIL auto_first_step: got step=%0b colour=%0d expected 1/%0d", step, colour, auto_seq[0]); end
        for (int s = 1; s < 6; s++) begin
            zero = 0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                if (step !== 1'b0) zero++;
            end
            tick(1);
            total++; if (step !== 1'b1 || colour !== auto_seq[s] || zero != 0) begin bad++; $display("FAIL auto_step%0d: got step=%0b colour=%0d early=%0d expected 1/%0d/0", s, step, colour, zero, auto_seq[s]); end
        end
        // Release right after the wrap step: the debounce delay lets one more step through.
        button = 1'b0;
        step_cnt = 0;
        tick(6);
        total++; if (colour !== 3'd2 || step_cnt != 1) begin bad++; $display("FAIL auto_release: got colour=%0d steps=%0d expected 2/1", colour, step_cnt); end
        tick(10);
        total++; if (colour !== 3'd2 || step_cnt != 1) begin bad++; $display("FAIL auto_pause: got colour=%0d steps=%0d expected 2/1", colour, step_cnt); end
        // Counter was frozen at 2 of 3: debounce (6 edges) + 2 more edges.
        button = 1'b1;
        k = 0;
        while (k < 20 && step !== 1'b1) begin tick(1); k++; end
        total++; if (k != 8 || colour !== 3'd3) begin bad++; $display("FAIL auto_resume: got edges=%0d colour=%0d expected 8/3", k, colour); end
    endtask

    task automatic test_mode_switch;
        int k;
        dwell = 8'd5;
        tick(2);
        mode = 2'b00;
        step_cnt = 0;
        tick(10);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL switch_idle_state: got %0d expected 0", state); end
        total++; if (step_cnt != 0 || colour !== 3'd3) begin bad++; $display("FAIL switch_idle_hold: got steps=%0d colour=%0d expected 0/3", step_cnt, colour); end
        mode = 2'b10;
        tick(1);
        total++; if (state !== 2'b10) begin bad++; $display("FAIL switch_auto_state: got %0d expected 2", state); end
        k = 1;
        while (k < 20 && step !== 1'b1) begin tick(1); k++; end
        total++; if (k != 7 || colour !== 3'd4) begin bad++; $display("FAIL switch_restart: got edges=%0d colour=%0d expected 7/4", k, colour); end
        dwell = 8'd9;
        step_cnt = 0;
        tick(5);
        total++; if (step_cnt != 0 || colour !== 3'd4) begin bad++; $display("FAIL dwell_before_lower: got steps=%0d colour=%0d expected 0/4", step_cnt, colour); end
        dwell = 8'd1;
        tick(1);
        total++; if (step !== 1'b1 || colour !== 3'd5) begin bad++; $display("FAIL dwell_lowered: got step=%0b colour=%0d expected 1/5", step, colour); end
    endtask

    task automatic test_reset_mid;
        int k;
        dwell = 8'd5;
        tick(3);
        #2 rst = 1'b1;
        #1;
        total++; if (colour !== 3'd1 || step !== 1'b0 || state !== 2'b00) begin bad++; $display("FAIL mid_reset: got colour=%0d step=%0b state=%0d expected 1/0/0", colour, step, state); end
        @(negedge clk);
        rst = 1'b0;
        // 2 sync + 4 debounce edges, then 6 edges of dwell counting.
        k = 0;
        while (k < 30 && step !== 1'b1) begin tick(1); k++; end
        total++; if (k != 12 || colour !== 3'd2) begin bad++; $display("FAIL mid_reset_restart: got edges=%0d colour=%0d expected 12/2", k, colour); end
    endtask

    task automatic test_back_to_back;
        button = 1'b0;
        mode = 2'b01;
        tick(10);
        total++; if (colour !== 3'd2 || state !== 2'b01) begin bad++; $display("FAIL b2b_setup: got colour=%0d state=%0d expected 2/1", colour, state); end
        button = 1'b1;
        tick(DB + 2);
        // The press pulse is live in this cycle; leave MANUAL at the same time.
        mode = 2'b00;
        tick(1);
        total++; if (step !== 1'b1 || colour !== 3'd3 || state !== 2'b00) begin bad++; $display("FAIL b2b_press_on_exit: got step=%0b colour=%0d state=%0d expected 1/3/0", step, colour, state); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_auto();
        test_mode_switch();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 4, giving the consecutive cycles a synchronised button level must differ before it is accepted (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the asynchronous, active-high reset.
REQ-004 The module SHALL have port button, input, 1 bit: the raw, asynchronous push-button level.
REQ-005 The module SHALL have port mode, input, 2 bits: 00 off, 01 manual, 10 auto, 11 off.
REQ-006 The module SHALL have port dwell, input, 8 bits: the auto-mode step interval minus one, in cycles.
REQ-007 The module SHALL have port colour, output, 3 bits: the current LED colour code, registered.
REQ-008 The module SHALL have port step, output, 1 bit: a registered one-cycle pulse marking each colour change.
REQ-009 The module SHALL have port state, output, 2 bits: the FSM state, encoded IDLE=00, MANUAL=01, AUTO=10.

Function
REQ-010 The button path SHALL be a 2-flop synchroniser producing btn_s, followed by a debouncer producing btn_db.
REQ-011 The debouncer SHALL work as follows: counter clears whenever btn_s==btn_db; otherwise counter increments; on the cycle counter==DEBOUNCE-1 with btn_s!=btn_db, btn_db<=btn_s and the counter clears.
REQ-012 press SHALL be a one-cycle internal pulse on a 0->1 transition of btn_db.
REQ-013 The FSM SHALL register mode every cycle: mode 01 -> MANUAL, 10 -> AUTO, 00 or 11 -> IDLE, taking effect on the next edge.
REQ-014 In IDLE, colour SHALL hold, step SHALL be 0, and the dwell counter SHALL be 0.
REQ-015 In MANUAL, each press pulse SHALL advance colour by exactly one on the next edge; holding the button SHALL produce no further steps.
REQ-016 In AUTO, while btn_db==1, the dwell counter SHALL increment each cycle; when counter>=dwell, colour advances and the counter clears, giving a step period of dwell+1 cycles (dwell=0 gives one step every cycle).
REQ-017 In AUTO, while btn_db==0, colour and the dwell counter SHALL hold (pause), and counting SHALL resume from the held value.
REQ-018 On entry to AUTO from any other state, the dwell counter SHALL clear to 0.
REQ-019 If dwell is lowered below the current count mid-interval, the next cycle SHALL step, because counter>=dwell.
REQ-020 The colour sequence SHALL be 001->010->011->100->101->110->001, wrapping from 6 to 1.
REQ-021 If colour is ever 000 or 111, the next edge SHALL force 001 in any state, with step=0 for that correction.
REQ-022 step SHALL be 1 for exactly the cycle in which the new colour value is first visible, and 0 otherwise.
REQ-023 In the same cycle, the FSM state decision SHALL use the current state: a press arriving in the cycle mode leaves 01 still steps, because the state is still MANUAL.
REQ-024 For the manual step latency, a raw button rise held stable SHALL change colour between DEBOUNCE+2 and DEBOUNCE+4 edges later.

Reset
REQ-025 While rst=1, regardless of clk: colour=001, step=0, state=IDLE, synchroniser flops=0, btn_db=0, and both counters=0.
REQ-026 Reset asserted mid-debounce or mid-dwell SHALL discard all progress; after release, behaviour SHALL be identical to power-up.
REQ-027 Release of rst SHALL be the only reset action; no other input SHALL reinitialise state.

Verification
REQ-028 The bench SHALL cover reset: assert rst between edges -> colour=001, step=0, state=00 immediately, before the next clk edge.
REQ-029 The bench SHALL cover manual mode: mode=01, DEBOUNCE=4, three clean presses of 20 cycles each -> colour 001->010->011->100, exactly three step pulses.
REQ-030 The bench SHALL cover bounce: mode=01, button toggled every 2 cycles for 20 cycles, then held high -> exactly one step, and no step during the toggling.
REQ-031 The bench SHALL cover auto mode: mode=10, dwell=3, button held -> a step every 4 cycles, colour wraps 110->001 on the 6th step; releasing the button freezes colour, and re-pressing resumes with the remaining count.
REQ-032 The bench SHALL cover mode switch and boundary: in AUTO at count 2 of dwell=5 switch mode to 00, then back to 10 -> no step in IDLE, and the counter restarts at 0 (first step 6 cycles after the return to AUTO); dwell changed from 9 to 1 at count 5 -> step on the next cycle.
